step_counter: RTL and testbench

Parametrised successor to the lab counter: an up/down counter with programmable step, programmable upper limit, wrap or saturate overflow handling, a clock-enable prescaler, synchronous load, a terminal-count pulse and a sticky overflow flag. It is the general-purpose counting primitive for the lab designs (timers, address generators, display drivers) and replaces the fixed 8-bit load-and-add counter.

---
 rtl/step_counter.sv | 106 ++++++++++
 tb/tb_step_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// Up/down counter with programmable step and upper limit, wrap or saturate at the bounds,
// a clock-enable prescaler, synchronous load, a terminal-count pulse and a sticky overflow flag.
module step_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PSC_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] v_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             dir_i,
    input  logic             sat_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic [PSC_W-1:0] div_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             tick;
    logic             hit;
    logic [WIDTH-1:0] s_eff;
    logic [WIDTH:0]   lim_p1;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   up_wrap;
    logic [WIDTH:0]   dn_wrap;

    // Boundary arithmetic is one bit wider so limit = all-ones still wraps modulo 2^WIDTH.
    always_comb begin
        s_eff   = (step_i > limit_i) ? limit_i : step_i;
        lim_p1  = {1'b0, limit_i} + {{WIDTH{1'b0}}, 1'b1};
        up_sum  = {1'b0, count_q} + {1'b0, s_eff};
        up_wrap = up_sum - lim_p1;
        dn_wrap = {1'b0, count_q} + lim_p1 - {1'b0, s_eff};
        tick    = en_i & ~ld_i & (psc_q == div_i);
    end

    always_comb begin
        count_d = count_q;
        psc_d   = psc_q;
        ovf_d   = ovf_q;
        hit     = 1'b0;

        if (ld_i) begin
            count_d = (v_i > limit_i) ? limit_i : v_i;
            psc_d   = '0;
        end else begin
            if (en_i) begin
                psc_d = tick ? '0 : psc_q + 1'b1;
            end
            if (tick && (s_eff != '0)) begin
                if (!dir_i) begin
                    if (up_sum <= {1'b0, limit_i}) begin
                        count_d = up_sum[WIDTH-1:0];
                    end else begin
                        hit     = 1'b1;
                        count_d = sat_i ? limit_i : up_wrap[WIDTH-1:0];
                    end
                end else begin
                    if (count_q >= s_eff) begin
                        count_d = count_q - s_eff;
                    end else begin
                        hit     = 1'b1;
                        count_d = sat_i ? '0 : dn_wrap[WIDTH-1:0];
                    end
                end
            end
        end

        tc_d = hit;
        // A same-cycle boundary hit overrides the clear.
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (hit) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            psc_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            psc_q   <= psc_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: directed scenarios plus randomized traffic against an integer
// reference model of the counting rules.
module tb_step_counter;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned PSC_W   = 4;
    localparam int          PSC_MOD = 1 << PSC_W;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             en, ld, dir, sat, clr_ovf;
    logic [WIDTH-1:0] v, step, limit;
    logic [PSC_W-1:0] div;
    logic [WIDTH-1:0] count;
    logic             tc, ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_count, m_psc, m_tc, m_ovf;

    always #5 clk = ~clk;

    step_counter #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .en_i     (en),
        .ld_i     (ld),
        .v_i      (v),
        .step_i   (step),
        .dir_i    (dir),
        .sat_i    (sat),
        .limit_i  (limit),
        .div_i    (div),
        .clr_ovf_i(clr_ovf),
        .count_o  (count),
        .tc_o     (tc),
        .ovf_o    (ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_psc   = 0;
        m_tc    = 0;
        m_ovf   = 0;
    endtask

    task automatic model_edge();
        int lim, s, c, hit;
        bit tick;
        lim  = int'(limit);
        hit  = 0;
        tick = 0;
        if (ld) begin
            m_count = (int'(v) < lim) ? int'(v) : lim;
            m_psc   = 0;
        end else begin
            if (en) begin
                if (m_psc == int'(div)) begin
                    tick  = 1;
                    m_psc = 0;
                end else begin
                    m_psc = (m_psc + 1) % PSC_MOD;
                end
            end
            s = (int'(step) < lim) ? int'(step) : lim;
            if (tick && s != 0) begin
                c = m_count;
                if (!dir) begin
                    if (c + s <= lim) m_count = c + s;
                    else begin
                        hit     = 1;
                        m_count = sat ? lim : c + s - (lim + 1);
                    end
                end else begin
                    if (c >= s) m_count = c - s;
                    else begin
                        hit     = 1;
                        m_count = sat ? 0 : c + (lim + 1) - s;
                    end
                end
            end
        end
        m_tc = hit;
        if (hit) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    // One clock: model advances on the edge, outputs checked on the following falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq({tag, ".count"}, 32'(count), 32'(m_count));
        check_eq({tag, ".tc"}, 32'(tc), 32'(m_tc));
        check_eq({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    endtask

    task automatic load(input int val);
        ld = 1'b1;
        v  = WIDTH'(val);
        cycle("load");
        ld = 1'b0;
    endtask

    initial begin
        int up_exp[4]  = '{3, 6, 9, 2};
        int up_tc[4]   = '{0, 0, 0, 1};
        int dn_exp[3]  = '{3, 0, 0};

        rst_ni = 1'b0;
        en = 1'b0; ld = 1'b0; dir = 1'b0; sat = 1'b0; clr_ovf = 1'b0;
        v = '0; step = 8'd1; limit = 8'd255; div = '0;
        model_reset();
        #2;
        check_eq("rst.count", 32'(count), 32'd0);
        check_eq("rst.tc", 32'(tc), 32'd0);
        check_eq("rst.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Async reset mid-count
        load(8'h5A);
        check_eq("pre_rst.count", 32'(count), 32'h5A);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst.count", 32'(count), 32'd0);
        check_eq("async_rst.tc", 32'(tc), 32'd0);
        check_eq("async_rst.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) cycle("rst_hold");

        // Up wrap
        limit = 8'd9; step = 8'd3; div = '0; sat = 1'b0; dir = 1'b0;
        load(0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("upwrap");
            check_eq("upwrap.const", 32'(count), 32'(up_exp[i]));
            check_eq("upwrap.tc_const", 32'(tc), 32'(up_tc[i]));
        end
        en = 1'b0;
        cycle("upwrap_hold");
        check_eq("upwrap.ovf_const", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        cycle("clr_ovf");
        clr_ovf = 1'b0;
        check_eq("clr_ovf.const", 32'(ovf), 32'd0);

        // Down saturate
        limit = 8'd200; step = 8'd7; dir = 1'b1; sat = 1'b1;
        load(10);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("dnsat");
            check_eq("dnsat.const", 32'(count), 32'(dn_exp[i]));
            check_eq("dnsat.tc_const", 32'(tc), 32'((i > 0) ? 1 : 0));
        end
        en = 1'b0;

        // Prescaler
        limit = 8'd255; step = 8'd1; dir = 1'b0; sat = 1'b0; div = 4'd3;
        load(0);
        en = 1'b1;
        for (int i = 0; i < 3; i++) cycle("psc");
        check_eq("psc.pre_tick", 32'(count), 32'd0);
        cycle("psc");
        check_eq("psc.tick1", 32'(count), 32'd1);
        cycle("psc");
        en = 1'b0;
        cycle("psc_gap");
        cycle("psc_gap");
        en = 1'b1;
        cycle("psc");
        cycle("psc");
        check_eq("psc.delayed_pre", 32'(count), 32'd1);
        cycle("psc");
        check_eq("psc.delayed_tick", 32'(count), 32'd2);

        // Priority: load beats a due tick, clamps to limit
        div = '0; limit = 8'd100;
        ld = 1'b1; v = 8'd250;
        cycle("prio_ld");
        ld = 1'b0;
        check_eq("prio_ld.const", 32'(count), 32'd100);
        check_eq("prio_ld.tc_const", 32'(tc), 32'd0);
        clr_ovf = 1'b1;
        cycle("prio_clr_hit");
        clr_ovf = 1'b0;
        check_eq("prio_clr_hit.ovf_const", 32'(ovf), 32'd1);

        // Full range
        limit = 8'd255; step = 8'd1; sat = 1'b0; dir = 1'b0; en = 1'b0;
        load(255);
        en = 1'b1;
        cycle("full_up");
        check_eq("full_up.const", 32'(count), 32'd0);
        check_eq("full_up.tc_const", 32'(tc), 32'd1);
        dir = 1'b1;
        cycle("full_dn");
        check_eq("full_dn.const", 32'(count), 32'd255);
        check_eq("full_dn.tc_const", 32'(tc), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            ld      = ($urandom_range(0, 19) == 0);
            v       = WIDTH'($urandom);
            dir     = 1'($urandom);
            clr_ovf = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) sat = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                step = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom)
                                                    : WIDTH'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 31) == 0) begin
                limit = ($urandom_range(0, 3) == 0) ? 8'd255 : WIDTH'($urandom);
            end
            if ($urandom_range(0, 31) == 0) div = PSC_W'($urandom_range(0, 3));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
